// File: rtl/video_pkg.sv
// Shared types for the video region scheduler: region layout, config
// field addresses and the commit state machine encoding.
package video_pkg;

    localparam int COORD_W     = 11;
    localparam int NUM_REGIONS = 4;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic       enable;
        logic [1:0] colour;
        coord_t     x_start;
        coord_t     x_end;
        coord_t     y_start;
        coord_t     y_end;
    } region_t;

    typedef enum logic [1:0] {
        X_START = 2'd0,
        X_END   = 2'd1,
        Y_START = 2'd2,
        Y_END   = 2'd3
    } field_e;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } cfg_state_e;

endpackage

// File: rtl/video_region_cmp.sv
// Single-rectangle hit test; inclusive bounds, unsigned compare.
module video_region_cmp #(
    parameter int COORD_W = 11
) (
    input  logic               enable,
    input  logic [COORD_W-1:0] x_start,
    input  logic [COORD_W-1:0] x_end,
    input  logic [COORD_W-1:0] y_start,
    input  logic [COORD_W-1:0] y_end,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic               hit
);
    import video_pkg::*;

    // An inverted rectangle (start > end) fails one of the bounds and never hits.
    assign hit = enable
               && (x >= x_start) && (x <= x_end)
               && (y >= y_start) && (y <= y_end);

endmodule

// File: rtl/video_region_ctrl.sv
// Raster tracker and prioritised region scheduler with shadowed config
// that is applied only on a vertical-blanking rising edge.
module video_region_ctrl #(
    parameter int NUM_REGIONS = 4,
    parameter int COORD_W     = 11
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cen_i,
    input  logic [3:0]         fvht_i,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [3:0]         cfg_addr_i,
    input  logic [15:0]        cfg_data_i,
    input  logic               cfg_commit_i,
    output logic               commit_done_o,
    output logic [3:0]         fvht_o,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               active_o,
    output logic               region_hit_o,
    output logic [1:0]         region_sel_o
);
    import video_pkg::*;

    logic [COORD_W-1:0]     x_cnt;
    logic [COORD_W-1:0]     y_cnt;
    logic [COORD_W-1:0]     x_cur;
    logic                   h_fall;
    logic                   h_rise;
    logic                   v_rise;
    logic                   active_cur;
    logic [NUM_REGIONS-1:0] hit;
    logic                   hit_any;
    logic [1:0]             sel;
    logic                   wr_en;
    logic                   unused_data;

    region_t    shadow_q [NUM_REGIONS];
    region_t    active_q [NUM_REGIONS];
    cfg_state_e state_q;

    // fvht_o doubles as the previous-sample register for edge detection.
    assign h_fall     = fvht_o[1] & ~fvht_i[1];
    assign h_rise     = ~fvht_o[1] & fvht_i[1];
    assign v_rise     = cen_i & fvht_i[2] & ~fvht_o[2];
    assign active_cur = ~fvht_i[1] & ~fvht_i[2];
    assign x_cur      = h_fall ? '0 : x_cnt;
    assign wr_en      = cfg_valid_i & cfg_ready_o;
    assign unused_data = ^cfg_data_i[12:11];

    for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_cmp
        video_region_cmp #(
            .COORD_W(COORD_W)
        ) u_cmp (
            .enable (active_q[i].enable),
            .x_start(active_q[i].x_start),
            .x_end  (active_q[i].x_end),
            .y_start(active_q[i].y_start),
            .y_end  (active_q[i].y_end),
            .x      (x_cur),
            .y      (y_cnt),
            .hit    (hit[i])
        );
    end

    // Walk from the top so the lowest-numbered hit is the last to land.
    always_comb begin
        hit_any = 1'b0;
        sel     = 2'd0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_any = 1'b1;
                sel     = active_q[i].colour;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fvht_o       <= '0;
            x_cnt        <= '0;
            y_cnt        <= '0;
            x_o          <= '0;
            y_o          <= '0;
            active_o     <= 1'b0;
            region_hit_o <= 1'b0;
            region_sel_o <= 2'd0;
        end else if (cen_i) begin
            fvht_o       <= fvht_i;
            active_o     <= active_cur;
            region_hit_o <= active_cur & hit_any;
            region_sel_o <= active_cur ? sel : 2'd0;
            if (active_cur) begin
                x_o <= x_cur;
                y_o <= y_cnt;
            end
            if (h_fall) begin
                x_cnt <= COORD_W'(1);
            end else if (!fvht_i[1] && x_cnt != '1) begin
                x_cnt <= x_cnt + 1'b1;
            end
            if (fvht_i[2]) begin
                y_cnt <= '0;
            end else if (h_rise && y_cnt != '1) begin
                y_cnt <= y_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            cfg_ready_o   <= 1'b0;
            commit_done_o <= 1'b0;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            commit_done_o <= 1'b0;
            if (wr_en) begin
                unique case (field_e'(cfg_addr_i[1:0]))
                    X_START: begin
                        shadow_q[cfg_addr_i[3:2]].x_start <= cfg_data_i[10:0];
                        shadow_q[cfg_addr_i[3:2]].enable  <= cfg_data_i[15];
                        shadow_q[cfg_addr_i[3:2]].colour  <= cfg_data_i[14:13];
                    end
                    X_END:   shadow_q[cfg_addr_i[3:2]].x_end   <= cfg_data_i[10:0];
                    Y_START: shadow_q[cfg_addr_i[3:2]].y_start <= cfg_data_i[10:0];
                    Y_END:   shadow_q[cfg_addr_i[3:2]].y_end   <= cfg_data_i[10:0];
                endcase
            end
            unique case (state_q)
                IDLE: begin
                    if (cfg_commit_i && cfg_ready_o) begin
                        state_q     <= PENDING;
                        cfg_ready_o <= 1'b0;
                    end else begin
                        cfg_ready_o <= 1'b1;
                    end
                end
                PENDING: begin
                    if (v_rise) begin
                        active_q      <= shadow_q;
                        commit_done_o <= 1'b1;
                        state_q       <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_region_ctrl.sv
// Directed bench for video_region_ctrl on a reduced 16x6 active raster.
module tb_video_region_ctrl;

    localparam int W  = 16;
    localparam int HB = 4;
    localparam int VB = 2;
    localparam int AL = 6;
    localparam int NL = VB + AL;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cen_i;
    logic [3:0]  fvht_i;
    logic        cfg_valid_i;
    logic        cfg_ready_o;
    logic [3:0]  cfg_addr_i;
    logic [15:0] cfg_data_i;
    logic        cfg_commit_i;
    logic        commit_done_o;
    logic [3:0]  fvht_o;
    logic [10:0] x_o;
    logic [10:0] y_o;
    logic        active_o;
    logic        region_hit_o;
    logic [1:0]  region_sel_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt, done_cyc, acc_cyc, hit_cnt, max_x, max_y, pend_cnt;
    bit hold_valid;
    bit frame_parity;
    int cap_sel [AL][W];
    int cap_hit [AL][W];

    video_region_ctrl #(
        .NUM_REGIONS(4),
        .COORD_W    (11)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cen_i        (cen_i),
        .fvht_i       (fvht_i),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_data_i   (cfg_data_i),
        .cfg_commit_i (cfg_commit_i),
        .commit_done_o(commit_done_o),
        .fvht_o       (fvht_o),
        .x_o          (x_o),
        .y_o          (y_o),
        .active_o     (active_o),
        .region_hit_o (region_hit_o),
        .region_sel_o (region_sel_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit acc;
        int pre;
        acc = cfg_valid_i && cfg_ready_o;
        pre = cyc;
        @(posedge clk_i);
        #1;
        cyc++;
        if (acc) begin
            acc_cyc = pre;
            if (hold_valid) begin
                hold_valid  = 1'b0;
                cfg_valid_i = 1'b0;
            end
        end
        if (commit_done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (hold_valid && !cfg_ready_o) pend_cnt++;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
        int n;
        n = 0;
        cfg_valid_i = 1'b1;
        cfg_addr_i  = a;
        cfg_data_i  = d;
        while (!cfg_ready_o && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("wr_timeout", n, 0);
        step();
        cfg_valid_i = 1'b0;
    endtask

    task automatic drive_frame(input int nl, input int ev_l, input int ev_k,
                               input bit ev_commit, input bit ev_write,
                               input logic [3:0] wa, input logic [15:0] wd);
        done_cnt = 0;
        hit_cnt  = 0;
        max_x    = 0;
        max_y    = 0;
        for (int y = 0; y < AL; y++)
            for (int x = 0; x < W; x++) begin
                cap_sel[y][x] = -1;
                cap_hit[y][x] = -1;
            end
        cen_i = 1'b1;
        for (int l = 0; l < nl; l++) begin
            for (int k = 0; k < W + HB; k++) begin
                bit h, v, ev;
                h  = (k >= W);
                v  = (l < VB);
                ev = (l == ev_l) && (k == ev_k);
                fvht_i = {frame_parity, v, h, k[0]};
                if (ev) begin
                    cfg_commit_i = ev_commit;
                    if (ev_write) begin
                        cfg_valid_i = 1'b1;
                        cfg_addr_i  = wa;
                        cfg_data_i  = wd;
                    end
                end
                step();
                cfg_commit_i = 1'b0;
                if (ev && ev_write) cfg_valid_i = 1'b0;
                chk("fvht_dly", fvht_o, fvht_i);
                chk("active", active_o, !h && !v);
                if (!h && !v) begin
                    chk("x", x_o, k);
                    chk("y", y_o, l - VB);
                    cap_sel[l-VB][k] = region_sel_o;
                    cap_hit[l-VB][k] = region_hit_o;
                    if (int'(x_o) > max_x) max_x = x_o;
                    if (int'(y_o) > max_y) max_y = y_o;
                end else begin
                    chk("blank_out", {region_hit_o, region_sel_o}, 0);
                end
                if (region_hit_o) hit_cnt++;
            end
        end
        frame_parity = ~frame_parity;
    endtask

    initial begin
        rst_i        = 1'b1;
        cen_i        = 1'b1;
        fvht_i       = 4'b0010;
        cfg_valid_i  = 1'b0;
        cfg_addr_i   = '0;
        cfg_data_i   = '0;
        cfg_commit_i = 1'b0;
        hold_valid   = 1'b0;
        frame_parity = 1'b0;
        acc_cyc      = -1;
        done_cyc     = -1;
        pend_cnt     = 0;
        step();
        step();
        chk("rst_outs", {fvht_o, x_o, y_o, active_o, region_hit_o, region_sel_o, commit_done_o}, 0);
        chk("rst_ready", cfg_ready_o, 0);
        rst_i = 1'b0;
        step();
        chk("ready_after_rst", cfg_ready_o, 1);

        // Idle raster, nothing configured
        drive_frame(NL, -1, -1, 1'b0, 1'b0, 4'h0, 16'h0);
        chk("f0_hits", hit_cnt, 0);
        chk("f0_max_x", max_x, W - 1);
        chk("f0_max_y", max_y, AL - 1);
        chk("f0_done", done_cnt, 0);

        // Region 0: x 0..9, y 0..3, colour 1; commit mid active line
        cen_i = 1'b0;
        cfg_write(4'h0, 16'hA000);
        cfg_write(4'h1, 16'd9);
        cfg_write(4'h2, 16'd0);
        cfg_write(4'h3, 16'd3);
        chk("cen_hold_x", x_o, W - 1);
        chk("cen_hold_y", y_o, AL - 1);
        drive_frame(NL, VB + 1, 3, 1'b1, 1'b0, 4'h0, 16'h0);
        chk("f1_hits", hit_cnt, 0);
        chk("f1_done", done_cnt, 0);
        chk("f1_ready", cfg_ready_o, 0);
        drive_frame(NL, -1, -1, 1'b0, 1'b0, 4'h0, 16'h0);
        chk("f2_done", done_cnt, 1);
        chk("f2_ready", cfg_ready_o, 1);
        chk("f2_sel_0_0", cap_sel[0][0], 1);
        chk("f2_sel_9_3", cap_sel[3][9], 1);
        chk("f2_hit_0_3", cap_hit[3][0], 1);
        chk("f2_hit_10_0", cap_hit[0][10], 0);
        chk("f2_sel_10_0", cap_sel[0][10], 0);
        chk("f2_hit_9_4", cap_hit[4][9], 0);

        // Four overlapping regions, region 3 inverted
        cen_i = 1'b0;
        cfg_write(4'h0, 16'hA000); cfg_write(4'h1, 16'd11);
        cfg_write(4'h2, 16'd0);    cfg_write(4'h3, 16'd3);
        cfg_write(4'h4, 16'hC008); cfg_write(4'h5, 16'd15);
        cfg_write(4'h6, 16'd0);    cfg_write(4'h7, 16'd5);
        cfg_write(4'h8, 16'hE000); cfg_write(4'h9, 16'd4);
        cfg_write(4'hA, 16'd4);    cfg_write(4'hB, 16'd5);
        cfg_write(4'hC, 16'hE007); cfg_write(4'hD, 16'd5);
        cfg_write(4'hE, 16'd0);    cfg_write(4'hF, 16'd5);
        cfg_commit_i = 1'b1;
        step();
        cfg_commit_i = 1'b0;
        chk("pend_ready", cfg_ready_o, 0);
        hold_valid  = 1'b1;
        pend_cnt    = 0;
        cfg_valid_i = 1'b1;
        cfg_addr_i  = 4'hC;
        cfg_data_i  = 16'hE007;
        step();
        step();
        step();
        chk("pend_blocked", pend_cnt, 3);
        drive_frame(NL, -1, -1, 1'b0, 1'b0, 4'h0, 16'h0);
        chk("f3_done", done_cnt, 1);
        chk("hold_acc_cyc", acc_cyc, done_cyc + 1);
        chk("f3_prio_9_0", cap_sel[0][9], 1);
        chk("f3_sel_11_0", cap_sel[0][11], 1);
        chk("f3_sel_7_0", cap_sel[0][7], 1);
        chk("f3_sel_12_0", cap_sel[0][12], 2);
        chk("f3_sel_9_4", cap_sel[4][9], 2);
        chk("f3_sel_3_4", cap_sel[4][3], 3);
        chk("f3_sel_4_4", cap_sel[4][4], 3);
        chk("f3_hit_5_4", cap_hit[4][5], 0);
        chk("f3_inv_6_4", cap_hit[4][6], 0);
        chk("f3_inv_7_4", cap_hit[4][7], 0);

        // Commit plus write on the V rising edge: applied a frame later
        drive_frame(NL, 0, 0, 1'b1, 1'b1, 4'h0, 16'hC002);
        chk("f4_done", done_cnt, 0);
        chk("f4_old_3_0", cap_sel[0][3], 1);
        chk("f4_old_0_0", cap_sel[0][0], 1);
        drive_frame(NL, -1, -1, 1'b0, 1'b0, 4'h0, 16'h0);
        chk("f5_done", done_cnt, 1);
        chk("f5_hit_0_0", cap_hit[0][0], 0);
        chk("f5_hit_1_0", cap_hit[0][1], 0);
        chk("f5_sel_2_0", cap_sel[0][2], 2);
        chk("f5_sel_3_0", cap_sel[0][3], 2);
        chk("f5_sel_3_4", cap_sel[4][3], 3);

        // Reset mid-frame with a commit pending
        drive_frame(VB + 3, VB + 1, 2, 1'b1, 1'b0, 4'h0, 16'h0);
        chk("f6_pending", cfg_ready_o, 0);
        rst_i  = 1'b1;
        fvht_i = 4'b0010;
        step();
        step();
        chk("rst2_outs", {fvht_o, x_o, y_o, active_o, region_hit_o, region_sel_o, commit_done_o}, 0);
        chk("rst2_ready", cfg_ready_o, 0);
        rst_i = 1'b0;
        step();
        chk("rst2_ready_after", cfg_ready_o, 1);
        drive_frame(NL, -1, -1, 1'b0, 1'b0, 4'h0, 16'h0);
        chk("f7_hits", hit_cnt, 0);
        chk("f7_done", done_cnt, 0);
        chk("f7_max_y", max_y, AL - 1);
        chk("f7_ready", cfg_ready_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_region_ctrl.md
# video_region_ctrl

Raster-position tracker and region scheduler that drives the source-select side of the video pattern path. It follows the incoming fvht timing, produces per-pixel coordinates, and resolves up to four prioritised rectangular regions into a colour index for the downstream pixel generator. Region settings are written through a valid/ready port into shadow registers. They take effect only at a vertical-blanking boundary, so a frame never shows a partially updated layout.

## Interface
Parameters:
- NUM_REGIONS, 4, number of rectangles; fixed by the 2-bit region field of cfg_addr_i.
- COORD_W, 11, coordinate width; coordinates run 0..2047.

Ports:
- clk_i  in  1  clock; the block uses one clock.
- rst_i  in  1  reset; synchronous, active-high.
- cen_i  in  1  clock enable; gates raster tracking only.
- fvht_i  in  4  timing: [3] F, [2] V (1 = vertical blank), [1] H (1 = horizontal blank), [0] T.
- cfg_valid_i  in  1  config write request.
- cfg_ready_o  out  1  config port can accept a write or a commit.
- cfg_addr_i  in  4  [3:2] region index, [1:0] field: 0 x_start, 1 x_end, 2 y_start, 3 y_end.
- cfg_data_i  in  16  [10:0] coordinate; in the x_start word only: [15] enable, [14:13] colour.
- cfg_commit_i  in  1  request to apply the shadow set at the next frame boundary.
- commit_done_o  out  1  one-cycle pulse when the shadow set has been applied.
- fvht_o  out  4  fvht_i delayed 1 cen cycle.
- x_o  out  COORD_W  active pixel index.
- y_o  out  COORD_W  active line index.
- active_o  out  1  H=0 and V=0.
- region_hit_o  out  1  pixel lies inside an enabled region.
- region_sel_o  out  2  colour of the winning region; 0 when region_hit_o=0.

## Operation
- Raster tracking, all updates qualified by cen_i:
  - An H falling edge starts a line. That pixel has x=0 and the counter loads 1.
  - While H=0 the counter increments and saturates at 2047.
  - The line counter clears while V=1.
  - While V=0, each H rising edge increments the line counter. The first active line is y=0. The line counter saturates at 2047.
- Region test: a region hits when it is enabled and x_start<=x<=x_end and y_start<=y<=y_end, unsigned compare. A region with start>end never hits.
- Priority: the lowest-numbered region that hits wins.
- Outside the active area, region_hit_o=0 and region_sel_o=0.
- Config writes:
  - A write is accepted when cfg_valid_i and cfg_ready_o are both high. It updates only the shadow field.
  - Writes to the x_start word also update enable and colour.
  - cfg_valid_i and cfg_commit_i are not gated by cen_i.
- Commit:
  - cfg_commit_i is accepted when cfg_ready_o=1. It sets the pending flag, and cfg_ready_o drops on the next cycle.
  - The shadow set is copied to the active set on the next cen-qualified V rising edge after the commit was accepted.
  - commit_done_o pulses that same cycle. cfg_ready_o returns to 1 on the following cycle.
- Same-cycle write and commit: the write lands in the shadow set first and is included in the commit.
- Commit accepted in the same cycle as a V rising edge: it is not applied at that edge. It waits for the next V rising edge.
- Reset, including reset while a commit is pending:
  - Shadow and active sets cleared, so all regions are disabled with zero coordinates.
  - Pending flag cleared and counters zeroed.

## Timing
- Latency: x_o, y_o, active_o, region_hit_o, region_sel_o and fvht_o are all registered. They appear 1 cen cycle after the fvht_i sample they describe and are mutually aligned.
- cen_i=0: all raster outputs hold their values.
- Reset values:
  - All outputs 0, except cfg_ready_o.
  - cfg_ready_o is 0 while rst_i is high and 1 from the first cycle after reset.
- Config state machine, two states:
  - IDLE: ready=1. On an accepted commit, go to PENDING.
  - PENDING: ready=0. On a V rising edge, apply the set, pulse commit_done_o and go to IDLE.

## Structure
- Package video_pkg holds:
  - COORD_W and NUM_REGIONS.
  - region_t struct: enable, colour[1:0], x_start, x_end, y_start, y_end.
  - Field-address enum: X_START, X_END, Y_START, Y_END.
  - Config state enum: IDLE, PENDING.
- Sub-module video_region_cmp: a combinational single-region hit test, instantiated NUM_REGIONS times. The priority encoder and output register stay in the top level.

## Test plan
- Reset then idle 1920x1080 raster, no config -> region_hit_o=0 throughout; x_o reaches 1919 on every line; y_o reaches 1079; fvht_o equals fvht_i delayed 1 cycle.
- Write region 0 as x 0..899, y 0..500, colour 1, enabled, then commit during an active line -> no change until the next V rising edge; commit_done_o pulses once; the next frame shows region_sel_o=1 at (0,0) and (899,500) and 0 at (900,0).
- Region 0 colour 1 over x 0..999 and region 1 colour 2 over x 900..1919, both y 0..1079 -> x=950 gives sel=1, x=1000 gives sel=2.
- Commit asserted in the same cycle as a V rising edge, together with a write -> applied one frame later, and the written value is included.
- cfg_valid_i held while PENDING -> not accepted (cfg_ready_o=0); accepted on the first cycle after commit_done_o.
- rst_i asserted mid-frame with a commit pending -> the next frame shows no hits, commit_done_o never fires, and cfg_ready_o=1 one cycle after rst_i falls.
